// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions for the 100GBASE-R transmit encoder and receive decoder.
package pcs_pkg;

  localparam int LEN_CODED_BLOCK = 66;
  localparam int LEN_TX_DATA     = 64;
  localparam int LEN_TX_CTRL     = 8;
  localparam int LEN_RX_DATA     = 64;
  localparam int LEN_RX_CTRL     = 8;

  // CGMII control characters
  localparam logic [7:0] CGMII_START     = 8'hFB;
  localparam logic [7:0] CGMII_TERMINATE = 8'hFD;
  localparam logic [7:0] CGMII_IDLE      = 8'h07;
  localparam logic [7:0] CGMII_ERROR     = 8'hFE;
  localparam logic [7:0] CGMII_SEQ       = 8'h9C;
  localparam logic [7:0] CGMII_SIG       = 8'h5C;

  // PCS 7-bit control characters and ordered-set codes
  localparam logic [6:0] PCS_IDLE  = 7'h00;
  localparam logic [6:0] PCS_ERROR = 7'h1E;
  localparam logic [3:0] O_SEQ     = 4'h0;
  localparam logic [3:0] O_SIG     = 4'hF;

  // Sync headers
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // Block type field values
  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_O  = 8'h4B;
  localparam logic [7:0] BT_S  = 8'h78;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'hAA;
  localparam logic [7:0] BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC;
  localparam logic [7:0] BT_T5 = 8'hD2;
  localparam logic [7:0] BT_T6 = 8'hE1;
  localparam logic [7:0] BT_T7 = 8'hFF;

  // Control-flag masks shared by both directions (bit 7 is lane 0)
  localparam logic [7:0] CTRL_ALL_DATA = 8'h00;
  localparam logic [7:0] CTRL_ALL_CTRL = 8'hFF;
  localparam logic [7:0] CTRL_LANE0    = 8'h80;

  // Block classification as {D,S,C,T}; all zero means error
  localparam logic [3:0] TX_TYPE_D = 4'b1000;
  localparam logic [3:0] TX_TYPE_S = 4'b0100;
  localparam logic [3:0] TX_TYPE_C = 4'b0010;
  localparam logic [3:0] TX_TYPE_T = 4'b0001;
  localparam logic [3:0] TX_TYPE_E = 4'b0000;

  // Fixed blocks
  localparam logic [65:0] IDLE_BLOCK = {SH_CTRL, BT_C, 56'h0};
  localparam logic [65:0] EBLOCK     = {SH_CTRL, BT_C, {8{PCS_ERROR}}};

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
  typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;

  // True for the CGMII characters allowed after a terminate or in an idle word
  function automatic logic is_idle_char(input logic [7:0] c);
    return (c == CGMII_IDLE) || (c == CGMII_ERROR);
  endfunction

  // Maps an idle/error CGMII character onto its 7-bit PCS form
  function automatic logic [6:0] cgmii_to_pcs(input logic [7:0] c);
    return (c == CGMII_ERROR) ? PCS_ERROR : PCS_IDLE;
  endfunction

  // Block type for a terminate in lane k
  function automatic logic [7:0] term_block_type(input logic [2:0] k);
    logic [7:0] bt;
    case (k)
      3'd0:    bt = BT_T0;
      3'd1:    bt = BT_T1;
      3'd2:    bt = BT_T2;
      3'd3:    bt = BT_T3;
      3'd4:    bt = BT_T4;
      3'd5:    bt = BT_T5;
      3'd6:    bt = BT_T6;
      default: bt = BT_T7;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/encoder_comparator.sv
// Combinational word classifier and candidate 66-bit block builder for the transmit encoder.
module encoder_comparator
  import pcs_pkg::*;
(
  input  logic [LEN_TX_DATA-1:0]     tx_data,
  input  logic [LEN_TX_CTRL-1:0]     tx_ctrl,
  output logic [3:0]                 t_type,
  output logic [LEN_CODED_BLOCK-1:0] tx_block
);

  logic [7:0] lane [8];
  logic [7:0] lane_idle;
  logic       term_hit;
  logic [2:0] term_pos;
  logic [55:0] payload;

  // Split the word into lanes (lane 0 is the most significant byte) and flag idle/error lanes
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane[i]      = tx_data[63-8*i -: 8];
      lane_idle[i] = is_idle_char(lane[i]);
    end
  end

  // Look for a legal terminate: ctrl = FF>>k, FD in lane k, only idle/error lanes after it
  always_comb begin
    logic tail_ok;
    term_hit = 1'b0;
    term_pos = '0;
    tail_ok  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tail_ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (j > k) tail_ok = tail_ok & lane_idle[j];
      end
      if ((tx_ctrl == (8'hFF >> k)) && (lane[k] == CGMII_TERMINATE) && tail_ok) begin
        term_hit = 1'b1;
        term_pos = 3'(k);
      end
    end
  end

  // Classify the word and assemble the block it would encode to if the FSM accepts it
  always_comb begin
    t_type   = TX_TYPE_E;
    tx_block = EBLOCK;
    payload  = '0;
    if (tx_ctrl == CTRL_ALL_DATA) begin
      t_type   = TX_TYPE_D;
      tx_block = {SH_DATA, tx_data};
    end else if ((tx_ctrl == CTRL_LANE0) && (lane[0] == CGMII_START)) begin
      t_type   = TX_TYPE_S;
      tx_block = {SH_CTRL, BT_S, tx_data[55:0]};
    end else if ((tx_ctrl == CTRL_LANE0) &&
                 ((lane[0] == CGMII_SEQ) || (lane[0] == CGMII_SIG))) begin
      t_type   = TX_TYPE_C;
      tx_block = {SH_CTRL, BT_O, tx_data[55:32],
                  (lane[0] == CGMII_SEQ) ? O_SEQ : O_SIG, 28'h0};
    end else if ((tx_ctrl == CTRL_ALL_CTRL) && (&lane_idle)) begin
      for (int i = 0; i < 8; i++) begin
        payload[(7-i)*7 +: 7] = cgmii_to_pcs(lane[i]);
      end
      t_type   = TX_TYPE_C;
      tx_block = {SH_CTRL, BT_C, payload};
    end else if (term_hit) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(term_pos)) begin
          payload[55-8*i -: 8] = lane[i];
        end else if (i > int'(term_pos)) begin
          payload[(7-i)*7 +: 7] = cgmii_to_pcs(lane[i]);
        end
      end
      t_type   = TX_TYPE_T;
      tx_block = {SH_CTRL, term_block_type(term_pos), payload};
    end
  end

endmodule

// File: rtl/tx_encoder.sv
// 64b/66b transmit encoder: block sequencing FSM, error-block override and registered outputs.
module tx_encoder
  import pcs_pkg::*;
(
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [LEN_TX_DATA-1:0]     i_tx_data,
  input  logic [LEN_TX_CTRL-1:0]     i_tx_ctrl,
  output logic [LEN_CODED_BLOCK-1:0] o_tx_coded,
  output logic [3:0]                 o_tx_type
);

  tx_state_t                  state;
  tx_state_t                  next_state;
  logic [3:0]                 word_type;
  logic [LEN_CODED_BLOCK-1:0] word_block;
  logic [LEN_CODED_BLOCK-1:0] next_coded;
  logic [3:0]                 next_type;

  encoder_comparator u_comparator (
    .tx_data  (i_tx_data),
    .tx_ctrl  (i_tx_ctrl),
    .t_type   (word_type),
    .tx_block (word_block)
  );

  // Choose the next state from the word class; anything landing in TX_E emits the error block
  always_comb begin
    next_state = state;
    next_coded = word_block;
    next_type  = word_type;
    case (state)
      TX_INIT, TX_C, TX_T: begin
        if (word_type == TX_TYPE_C)      next_state = TX_C;
        else if (word_type == TX_TYPE_S) next_state = TX_D;
        else                             next_state = TX_E;
      end
      TX_D: begin
        if (word_type == TX_TYPE_D)      next_state = TX_D;
        else if (word_type == TX_TYPE_T) next_state = TX_T;
        else                             next_state = TX_E;
      end
      TX_E: begin
        if (word_type == TX_TYPE_C)      next_state = TX_C;
        else if (word_type == TX_TYPE_D) next_state = TX_D;
        else if (word_type == TX_TYPE_T) next_state = TX_T;
        else                             next_state = TX_E;
      end
      default: next_state = TX_E;
    endcase
    if (next_state == TX_E) begin
      next_coded = EBLOCK;
      next_type  = TX_TYPE_E;
    end
  end

  // Register state and outputs; a low enable freezes everything
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= TX_INIT;
      o_tx_coded <= IDLE_BLOCK;
      o_tx_type  <= TX_TYPE_C;
    end else if (i_enable) begin
      state      <= next_state;
      o_tx_coded <= next_coded;
      o_tx_type  <= next_type;
    end
  end

endmodule

// File: tb/tb_tx_encoder.sv
// Self-checking bench for tx_encoder: golden vectors plus a reference model feeding a scoreboard.
module tb_tx_encoder;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [63:0] i_tx_data;
  logic [7:0]  i_tx_ctrl;
  logic [65:0] o_tx_coded;
  logic [3:0]  o_tx_type;

  localparam logic [65:0] IDLE_BLK = {2'b10, 8'h1E, 56'h0};
  localparam logic [65:0] E_BLK    = {2'b10, 8'h1E, {8{7'h1E}}};

  typedef struct {
    string       tag;
    logic [65:0] coded;
    logic [3:0]  ty;
  } exp_t;

  typedef enum int {M_INIT, M_C, M_D, M_T, M_E} mstate_t;

  exp_t        expQueue[$];
  int          checks = 0;
  int          errors = 0;
  mstate_t     mState = M_INIT;
  logic [65:0] mCoded;
  logic [3:0]  mType;

  tx_encoder dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_tx_data  (i_tx_data),
    .i_tx_ctrl  (i_tx_ctrl),
    .o_tx_coded (o_tx_coded),
    .o_tx_type  (o_tx_type)
  );

  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string tag, input logic [65:0] observed, input logic [65:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] pcsChar(input logic [7:0] c);
    return (c == 8'hFE) ? 7'h1E : 7'h00;
  endfunction

  // Reference encoding of one word, written from the coding tables
  function automatic void refEncode(input logic [63:0] d, input logic [7:0] c,
                                    output logic [3:0] ty, output logic [65:0] blk);
    logic [7:0]  b [8];
    logic [7:0]  tTypes [8];
    logic [55:0] acc;
    int          p;
    bit          ctrlOk;
    bit          tailOk;
    bit          allIdle;
    tTypes = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    for (int i = 0; i < 8; i++) b[i] = d[63-8*i -: 8];
    ty  = 4'b0000;
    blk = E_BLK;
    acc = '0;
    if (c == 8'h00) begin
      ty  = 4'b1000;
      blk = {2'b01, d};
    end else if (c == 8'h80 && b[0] == 8'hFB) begin
      ty  = 4'b0100;
      blk = {2'b10, 8'h78, d[55:0]};
    end else if (c == 8'h80 && (b[0] == 8'h9C || b[0] == 8'h5C)) begin
      ty  = 4'b0010;
      blk = {2'b10, 8'h4B, b[1], b[2], b[3], (b[0] == 8'h9C) ? 4'h0 : 4'hF, 28'h0};
    end else begin
      p = -1;
      allIdle = 1;
      for (int i = 0; i < 8; i++) begin
        if (p < 0 && c[7-i] && b[i] == 8'hFD) p = i;
        if (!(b[i] == 8'h07 || b[i] == 8'hFE)) allIdle = 0;
      end
      if (p < 0) begin
        if (c == 8'hFF && allIdle) begin
          for (int i = 0; i < 8; i++) acc = {acc[48:0], pcsChar(b[i])};
          ty  = 4'b0010;
          blk = {2'b10, 8'h1E, acc};
        end
      end else begin
        ctrlOk = 1;
        tailOk = 1;
        for (int i = 0; i < 8; i++) begin
          if (c[7-i] != (i >= p)) ctrlOk = 0;
          if (i > p && !(b[i] == 8'h07 || b[i] == 8'hFE)) tailOk = 0;
        end
        if (ctrlOk && tailOk) begin
          for (int i = 0; i < p; i++) acc = {acc[47:0], b[i]};
          acc = acc << (7 - p);
          for (int i = p + 1; i < 8; i++) acc = {acc[48:0], pcsChar(b[i])};
          ty  = 4'b0001;
          blk = {2'b10, tTypes[p], acc};
        end
      end
    end
  endfunction

  // Drive one cycle, advance the reference model and queue its expected output
  task automatic applyStimulus(input string tag, input logic rst, input logic en,
                               input logic [63:0] d, input logic [7:0] c);
    logic [3:0]  ty;
    logic [65:0] blk;
    mstate_t     nxt;
    exp_t        e;
    @(negedge i_clock);
    i_reset   = rst;
    i_enable  = en;
    i_tx_data = d;
    i_tx_ctrl = c;
    if (rst) begin
      mState = M_INIT;
      mCoded = IDLE_BLK;
      mType  = 4'b0010;
    end else if (en) begin
      refEncode(d, c, ty, blk);
      nxt = M_E;
      case (mState)
        M_D:     nxt = ty[3] ? M_D : (ty[0] ? M_T : M_E);
        M_E:     nxt = ty[1] ? M_C : (ty[3] ? M_D : (ty[0] ? M_T : M_E));
        default: nxt = ty[1] ? M_C : (ty[2] ? M_D : M_E);
      endcase
      if (nxt == M_E) begin
        mCoded = E_BLK;
        mType  = 4'b0000;
      end else begin
        mCoded = blk;
        mType  = ty;
      end
      mState = nxt;
    end
    e.tag   = tag;
    e.coded = mCoded;
    e.ty    = mType;
    expQueue.push_back(e);
  endtask

  // Same as applyStimulus but the expected block comes from a hand-derived constant
  task automatic applyGolden(input string tag, input logic rst, input logic en,
                             input logic [63:0] d, input logic [7:0] c,
                             input logic [65:0] gCoded, input logic [3:0] gType);
    applyStimulus(tag, rst, en, d, c);
    expQueue[expQueue.size()-1].coded = gCoded;
    expQueue[expQueue.size()-1].ty    = gType;
  endtask

  function automatic logic [63:0] makeTerm(input int k);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      if (i < k)       w[63-8*i -: 8] = 8'($urandom);
      else if (i == k) w[63-8*i -: 8] = 8'hFD;
      else             w[63-8*i -: 8] = $urandom_range(0, 1) ? 8'h07 : 8'hFE;
    end
    return w;
  endfunction

  // Scoreboard: compare each queued expectation one tick after the edge that produced it
  always @(posedge i_clock) begin
    exp_t e;
    #1;
    if (expQueue.size() > 0) begin
      e = expQueue.pop_front();
      checkOutput($sformatf("%s/coded", e.tag), o_tx_coded, e.coded);
      checkOutput($sformatf("%s/type", e.tag), 66'(o_tx_type), 66'(e.ty));
    end
  end

  initial begin
    logic [63:0] w;
    i_reset   = 1'b1;
    i_enable  = 1'b0;
    i_tx_data = '0;
    i_tx_ctrl = '0;

    applyGolden("reset", 1, 1, 64'h0, 8'h00, IDLE_BLK, 4'b0010);
    for (int i = 0; i < 3; i++)
      applyGolden("idle", 0, 1, {8{8'h07}}, 8'hFF, IDLE_BLK, 4'b0010);
    applyGolden("start", 0, 1, 64'hFB555555555555D5, 8'h80,
                {2'b10, 8'h78, 56'h555555555555D5}, 4'b0100);
    applyGolden("data", 0, 1, 64'h0011223344556677, 8'h00,
                {2'b01, 64'h0011223344556677}, 4'b1000);
    applyGolden("term3", 0, 1, 64'hD0D1D2FD07070707, 8'h1F,
                {2'b10, 8'hB4, 24'hD0D1D2, 4'h0, 28'h0}, 4'b0001);
    applyGolden("idle_after_t", 0, 1, {8{8'h07}}, 8'hFF, IDLE_BLK, 4'b0010);
    applyGolden("d_in_c", 0, 1, 64'h0123456789ABCDEF, 8'h00, E_BLK, 4'b0000);
    applyGolden("idle_recover", 0, 1, {8{8'h07}}, 8'hFF, IDLE_BLK, 4'b0010);
    applyGolden("ordered_set", 0, 1, 64'h9C00000100000000, 8'h80,
                {2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0}, 4'b0010);
    applyGolden("idle_err", 0, 1, 64'h07FE0707070707FE, 8'hFF,
                {2'b10, 8'h1E, 7'h00, 7'h1E, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h1E}, 4'b0010);
    applyGolden("start2", 0, 1, 64'hFB0102030405060F, 8'h80,
                {2'b10, 8'h78, 56'h0102030405060F}, 4'b0100);
    applyGolden("data2", 0, 1, 64'hCAFEF00DDEADBEEF, 8'h00,
                {2'b01, 64'hCAFEF00DDEADBEEF}, 4'b1000);
    applyGolden("hold1", 0, 0, {8{8'h07}}, 8'hFF, {2'b01, 64'hCAFEF00DDEADBEEF}, 4'b1000);
    applyGolden("hold2", 0, 0, 64'hFB00000000000000, 8'h80, {2'b01, 64'hCAFEF00DDEADBEEF}, 4'b1000);
    applyGolden("data_after_hold", 0, 1, 64'h1122334455667788, 8'h00,
                {2'b01, 64'h1122334455667788}, 4'b1000);
    applyGolden("reset_mid", 1, 1, 64'h99AA99AA99AA99AA, 8'h00, IDLE_BLK, 4'b0010);
    applyGolden("start_after_reset", 0, 1, 64'hFB00112233445566, 8'h80,
                {2'b10, 8'h78, 56'h00112233445566}, 4'b0100);
    applyGolden("bad_term", 0, 1, 64'h0102FD0707550707, 8'h3F, E_BLK, 4'b0000);
    applyGolden("d_after_e", 0, 1, 64'h5A5A5A5A5A5A5A5A, 8'h00,
                {2'b01, 64'h5A5A5A5A5A5A5A5A}, 4'b1000);
    applyGolden("c_in_d", 0, 1, {8{8'h07}}, 8'hFF, E_BLK, 4'b0000);
    applyGolden("s_in_e", 0, 1, 64'hFB00000000000000, 8'h80, E_BLK, 4'b0000);
    applyGolden("sig_os_from_e", 0, 1, 64'h5CA1B2C300000000, 8'h80,
                {2'b10, 8'h4B, 24'hA1B2C3, 4'hF, 28'h0}, 4'b0010);

    // Every terminate position, each inside a fresh packet
    for (int k = 0; k < 8; k++) begin
      applyStimulus("tk_start", 0, 1, 64'hFB55555555555555, 8'h80);
      applyStimulus("tk_data", 0, 1, {$urandom, $urandom}, 8'h00);
      w = makeTerm(k);
      applyStimulus($sformatf("term%0d", k), 0, 1, w, 8'hFF >> k);
      applyStimulus("tk_idle", 0, 1, {8{8'h07}}, 8'hFF);
    end

    // Mixed random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1: w = {$urandom, $urandom};
        2:    w = {8'hFB, 24'($urandom), 32'($urandom)};
        3:    w = makeTerm($urandom_range(0, 7));
        4:    w = {8'h9C, 24'($urandom), 32'h0};
        5:    w = {$urandom_range(0, 1) ? 8'h07 : 8'hFE, {7{8'h07}}};
        default: w = {$urandom, $urandom};
      endcase
      case (sel)
        0, 1:    applyStimulus("rnd_d", 0, ($urandom_range(0, 7) != 0), w, 8'h00);
        2:       applyStimulus("rnd_s", 0, 1, w, 8'h80);
        3: begin
          int k;
          k = 0;
          for (int i = 7; i >= 0; i--) if (w[63-8*i -: 8] == 8'hFD) k = i;
          applyStimulus("rnd_t", 0, 1, w, 8'hFF >> k);
        end
        4:       applyStimulus("rnd_os", 0, 1, w, 8'h80);
        5:       applyStimulus("rnd_idle", 0, ($urandom_range(0, 7) != 0), w, 8'hFF);
        default: applyStimulus("rnd_junk", 0, 1, w, 8'($urandom));
      endcase
    end

    @(negedge i_clock);
    @(negedge i_clock);
    checkOutput("scoreboard_drain", 66'(expQueue.size()), 66'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
